// File: rtl/intercal_alu_seq_if.sv
// Host register-file access and command handshake bundle for intercal_alu_seq.
interface intercal_alu_seq_if #(
    parameter int unsigned W    = 32,
    parameter int unsigned NREG = 4
);
    localparam int unsigned AW = $clog2(NREG);
    localparam int unsigned BW = $clog2(W / 8);

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [BW-1:0] wr_byte;
    logic [7:0]    wr_data;
    logic [AW-1:0] rd_addr;
    logic [BW-1:0] rd_byte;
    logic [7:0]    rd_data;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic          cmd_half;
    logic [AW-1:0] cmd_dst;
    logic [AW-1:0] cmd_srca;
    logic [AW-1:0] cmd_srcb;
    logic          done;
    logic          err;

    modport master (
        output wr_en, wr_addr, wr_byte, wr_data, rd_addr, rd_byte,
        output cmd_valid, cmd_op, cmd_half, cmd_dst, cmd_srca, cmd_srcb,
        input  rd_data, cmd_ready, done, err
    );

    modport slave (
        input  wr_en, wr_addr, wr_byte, wr_data, rd_addr, rd_byte,
        input  cmd_valid, cmd_op, cmd_half, cmd_dst, cmd_srca, cmd_srcb,
        output rd_data, cmd_ready, done, err
    );
endinterface

// File: rtl/intercal_alu_seq.sv
// Multi-cycle INTERCAL ALU over a bytewise host-loaded register file.
// SELECT runs bit-serially; every command ends with a one-cycle done pulse.
module intercal_alu_seq #(
    parameter int unsigned W    = 32,
    parameter int unsigned NREG = 4
) (
    input logic              clk,
    input logic              rst_n,
    intercal_alu_seq_if.slave bus
);
    localparam int unsigned HW = W / 2;
    localparam int unsigned AW = $clog2(NREG);
    localparam int unsigned KW = $clog2(W);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SEL} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    regs_q [NREG];
    logic [2:0]      op_q;
    logic            half_q;
    logic [AW-1:0]   dst_q;
    logic [W-1:0]    a_q, b_q, res_q, res_d;
    logic [KW-1:0]   k_q, k_d, ptr_q, ptr_d, k_last;
    logic [W-1:0]    f_exec, alu_wdata, mask;
    logic            accept, alu_we, done_d, err_d, done_q, err_q;

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rd_data   = regs_q[bus.rd_addr][{bus.rd_byte, 3'b000} +: 8];
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign mask          = half_q ? W'({HW{1'b1}}) : '1;
    assign k_last        = half_q ? KW'(HW - 1) : KW'(W - 1);

    // Single-cycle ops on the snapshotted operands
    always_comb begin
        int unsigned lcur;
        int unsigned j;
        f_exec = '0;
        lcur   = half_q ? HW : W;
        j      = 0;
        case (op_q)
            3'd0: f_exec = a_q & mask;
            3'd1: begin
                for (int unsigned i = 0; i < HW; i++) begin
                    if (!half_q || i < HW / 2) begin
                        f_exec[2*i+1] = a_q[i];
                        f_exec[2*i]   = b_q[i];
                    end
                end
            end
            3'd3, 3'd4, 3'd5: begin
                for (int unsigned i = 0; i < W; i++) begin
                    if (i < lcur) begin
                        j = (i == lcur - 1) ? 0 : i + 1;
                        case (op_q)
                            3'd3:    f_exec[i] = a_q[i] & a_q[j];
                            3'd4:    f_exec[i] = a_q[i] | a_q[j];
                            default: f_exec[i] = a_q[i] ^ a_q[j];
                        endcase
                    end
                end
            end
            default: f_exec = '0;
        endcase
    end

    // One select step: pack a[k] at ptr when b[k] is set
    always_comb begin
        res_d = res_q;
        ptr_d = ptr_q;
        if (b_q[k_q]) begin
            res_d[ptr_q] = a_q[k_q];
            ptr_d        = ptr_q + 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        alu_we    = 1'b0;
        alu_wdata = f_exec;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (bus.cmd_op == 3'd2) ? S_SEL : S_EXEC;
                    k_d     = '0;
                end
            end
            S_EXEC: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (op_q >= 3'd6) begin
                    err_d = 1'b1;
                end else begin
                    alu_we = 1'b1;
                end
            end
            S_SEL: begin
                alu_wdata = res_d;
                if (k_q == k_last) begin
                    alu_we  = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            ptr_q   <= '0;
            res_q   <= '0;
            op_q    <= '0;
            half_q  <= 1'b0;
            dst_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (accept) begin
                op_q   <= bus.cmd_op;
                half_q <= bus.cmd_half;
                dst_q  <= bus.cmd_dst;
                a_q    <= regs_q[bus.cmd_srca];
                b_q    <= regs_q[bus.cmd_srcb];
                res_q  <= '0;
                ptr_q  <= '0;
            end else if (state_q == S_SEL) begin
                res_q <= res_d;
                ptr_q <= ptr_d;
            end
        end
    end

    // ALU write takes the whole register over a colliding host byte write
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NREG; i++) begin
            if (!rst_n) begin
                regs_q[i] <= '0;
            end else if (alu_we && dst_q == AW'(i)) begin
                regs_q[i] <= alu_wdata;
            end else if (bus.wr_en && bus.wr_addr == AW'(i)) begin
                regs_q[i][{bus.wr_byte, 3'b000} +: 8] <= bus.wr_data;
            end
        end
    end
endmodule

// File: tb/tb_intercal_alu_seq.sv
// Directed bench for intercal_alu_seq with a cycle-level reference model.
module tb_intercal_alu_seq;
    localparam int unsigned W    = 32;
    localparam int unsigned NREG = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    intercal_alu_seq_if #(.W(W), .NREG(NREG)) bus ();

    intercal_alu_seq #(.W(W), .NREG(NREG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_done = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: operations from their definitions, latency as a countdown
    logic [31:0] m_reg [4];
    int          m_busy = 0;
    logic [1:0]  m_dst;
    logic [31:0] m_res;
    bit          m_rsv, m_done, m_err, m_on;

    function automatic logic [31:0] f_mingle(input logic [31:0] a, b, input int l);
        logic [31:0] r = '0;
        for (int i = 0; i < l / 2; i++) begin
            r[2*i+1] = a[i];
            r[2*i]   = b[i];
        end
        return r;
    endfunction

    function automatic logic [31:0] f_select(input logic [31:0] a, b, input int l);
        logic [31:0] r = '0;
        int n = 0;
        for (int i = 0; i < l; i++) begin
            if (b[i]) begin
                r[n] = a[i];
                n++;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] f_unary(input logic [2:0] op, input logic [31:0] a, input int l);
        logic [31:0] msk = (l == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        logic [31:0] ar  = a & msk;
        logic [31:0] rot = ((ar >> 1) | (ar << (l - 1))) & msk;
        case (op)
            3'd3:    return ar & rot;
            3'd4:    return ar | rot;
            default: return ar ^ rot;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [31:0] sa, sb;
        int l;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_reg[i] = '0;
            m_busy = 0;
            m_done = 0;
            m_err  = 0;
            m_on   = 1;
        end else begin
            sa = m_reg[bus.cmd_srca];
            sb = m_reg[bus.cmd_srcb];
            m_done = 0;
            m_err  = 0;
            if (bus.wr_en) m_reg[bus.wr_addr][bus.wr_byte*8 +: 8] = bus.wr_data;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_done = 1;
                    m_err  = m_rsv;
                    if (!m_rsv) m_reg[m_dst] = m_res;
                end
            end else if (bus.cmd_valid) begin
                l      = bus.cmd_half ? 16 : 32;
                m_dst  = bus.cmd_dst;
                m_rsv  = (bus.cmd_op >= 3'd6);
                m_busy = (bus.cmd_op == 3'd2) ? l : 1;
                case (bus.cmd_op)
                    3'd0:             m_res = sa & ((l == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF);
                    3'd1:             m_res = f_mingle(sa, sb, l);
                    3'd2:             m_res = f_select(sa, sb, l);
                    3'd3, 3'd4, 3'd5: m_res = f_unary(bus.cmd_op, sa, l);
                    default:          m_res = '0;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("cmd_ready", {31'b0, bus.cmd_ready}, {31'b0, m_busy == 0});
            chk("done", {31'b0, bus.done}, {31'b0, m_done});
            chk("err", {31'b0, bus.err}, {31'b0, m_err});
            chk("rd_data", {24'b0, bus.rd_data}, {24'b0, m_reg[bus.rd_addr][bus.rd_byte*8 +: 8]});
            if (bus.done === 1'b1) n_done++;
        end
    end

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    task automatic hw(input logic [1:0] addr, input logic [1:0] lane, input logic [7:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_byte = lane;
        bus.wr_data = data;
        sync();
        bus.wr_en = 1'b0;
    endtask

    task automatic set_reg(input logic [1:0] addr, input logic [31:0] v);
        for (int l = 0; l < 4; l++) hw(addr, 2'(l), v[l*8 +: 8]);
    endtask

    task automatic read_reg(input logic [1:0] addr, output logic [31:0] v);
        for (int l = 0; l < 4; l++) begin
            bus.rd_addr = addr;
            bus.rd_byte = 2'(l);
            #1;
            v[l*8 +: 8] = bus.rd_data;
        end
    endtask

    task automatic expect_reg(input string nm, input logic [1:0] addr, input logic [31:0] v);
        logic [31:0] got;
        read_reg(addr, got);
        chk(nm, got, v);
    endtask

    // Issues a command; returns cycles with cmd_ready low and err seen with done.
    // An optional host byte write lands on the edge after acceptance.
    task automatic run_cmd(input logic [2:0] op, input logic half, input logic [1:0] dst,
                           input logic [1:0] sa, input logic [1:0] sb, input bit hw_en,
                           input logic [1:0] hw_addr, input logic [7:0] hw_data,
                           output int lat, output logic got_err);
        bit got = 0;
        bus.cmd_op    = op;
        bus.cmd_half  = half;
        bus.cmd_dst   = dst;
        bus.cmd_srca  = sa;
        bus.cmd_srcb  = sb;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #2;
        bus.cmd_valid = 1'b0;
        if (hw_en) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = hw_addr;
            bus.wr_byte = 2'd0;
            bus.wr_data = hw_data;
            fork
                begin
                    @(posedge clk);
                    #2;
                    bus.wr_en = 1'b0;
                end
            join_none
        end
        lat     = 0;
        got_err = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                got     = 1;
                got_err = bus.err;
            end else if (bus.cmd_ready === 1'b0) begin
                lat++;
            end
        end
        chk("done_seen", {31'b0, got}, 32'd1);
    endtask

    initial begin
        int lat, nd0;
        logic e;
        logic [31:0] v1, v2, v3;
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_byte = 0; bus.wr_data = 0;
        bus.rd_addr = 0; bus.rd_byte = 0;
        bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_half = 0;
        bus.cmd_dst = 0; bus.cmd_srca = 0; bus.cmd_srcb = 0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'b0, bus.cmd_ready}, 32'd1);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_err", {31'b0, bus.err}, 32'd0);
        sync();
        for (int r = 0; r < 4; r++) expect_reg("rst_reg", 2'(r), 32'h0);

        hw(2'd0, 2'd0, 8'hFF); hw(2'd0, 2'd1, 8'hFF);
        hw(2'd0, 2'd2, 8'h00); hw(2'd0, 2'd3, 8'h00);
        expect_reg("load_r0", 2'd0, 32'h0000_FFFF);
        for (int r = 1; r < 4; r++) expect_reg("load_rx", 2'(r), 32'h0);

        run_cmd(3'd1, 1'b0, 2'd2, 2'd0, 2'd1, 0, 2'd0, 8'h0, lat, e);
        chk("mingle_busy", lat, 1);
        chk("model_mingle", m_reg[2], 32'hAAAA_AAAA);
        sync();
        expect_reg("mingle_r2", 2'd2, 32'hAAAA_AAAA);

        set_reg(2'd0, 32'h1234_5678); set_reg(2'd1, 32'h0000_FFFF);
        run_cmd(3'd2, 1'b0, 2'd3, 2'd0, 2'd1, 1, 2'd0, 8'h00, lat, e);
        chk("sel_busy", lat, 32);
        sync();
        expect_reg("sel_snapshot", 2'd3, 32'h0000_5678);
        set_reg(2'd0, 32'h1234_5678);
        run_cmd(3'd2, 1'b1, 2'd2, 2'd0, 2'd1, 0, 2'd0, 8'h0, lat, e);
        chk("selh_busy", lat, 16);
        sync();
        expect_reg("selh_r2", 2'd2, 32'h0000_5678);
        set_reg(2'd0, 32'hDEAD_BEEF); set_reg(2'd1, 32'h8000_0001);
        run_cmd(3'd2, 1'b0, 2'd3, 2'd0, 2'd1, 0, 2'd0, 8'h0, lat, e);
        chk("model_sel", m_reg[3], 32'h0000_0003);
        sync();
        expect_reg("sel_ends", 2'd3, 32'h0000_0003);

        set_reg(2'd0, 32'h0000_0001);
        run_cmd(3'd5, 1'b0, 2'd2, 2'd0, 2'd0, 0, 2'd0, 8'h0, lat, e);
        chk("model_xor", m_reg[2], 32'h8000_0001);
        sync();
        expect_reg("xor_full", 2'd2, 32'h8000_0001);
        run_cmd(3'd5, 1'b1, 2'd2, 2'd0, 2'd0, 0, 2'd0, 8'h0, lat, e);
        sync();
        expect_reg("xor_half", 2'd2, 32'h0000_8001);
        set_reg(2'd0, 32'hFFFF_FFFF);
        run_cmd(3'd3, 1'b0, 2'd3, 2'd0, 2'd0, 0, 2'd0, 8'h0, lat, e);
        sync();
        expect_reg("and_ones", 2'd3, 32'hFFFF_FFFF);
        set_reg(2'd0, 32'h0000_0000);
        run_cmd(3'd4, 1'b0, 2'd3, 2'd0, 2'd0, 0, 2'd0, 8'h0, lat, e);
        sync();
        expect_reg("or_zero", 2'd3, 32'h0000_0000);

        set_reg(2'd1, 32'hCAFE_F00D);
        run_cmd(3'd0, 1'b0, 2'd2, 2'd1, 2'd0, 1, 2'd2, 8'h55, lat, e);
        sync();
        expect_reg("mov_collide", 2'd2, 32'hCAFE_F00D);

        set_reg(2'd0, 32'h0BAD_0BAD); set_reg(2'd3, 32'h3333_3333);
        read_reg(2'd1, v1); read_reg(2'd2, v2); read_reg(2'd3, v3);
        run_cmd(3'd6, 1'b0, 2'd0, 2'd1, 2'd1, 0, 2'd0, 8'h0, lat, e);
        chk("rsv_err", {31'b0, e}, 32'd1);
        chk("rsv_busy", lat, 1);
        chk("rsv_ready_in_done", {31'b0, bus.cmd_ready}, 32'd1);
        run_cmd(3'd0, 1'b0, 2'd0, 2'd1, 2'd1, 0, 2'd0, 8'h0, lat, e);
        chk("mov_after_rsv_err", {31'b0, e}, 32'd0);
        sync();
        expect_reg("mov_after_rsv", 2'd0, 32'hCAFE_F00D);
        expect_reg("rsv_r1", 2'd1, v1);
        expect_reg("rsv_r2", 2'd2, v2);
        expect_reg("rsv_r3", 2'd3, v3);

        set_reg(2'd2, 32'h1111_1111);
        set_reg(2'd0, 32'h1234_5678); set_reg(2'd1, 32'h0000_FFFF);
        nd0 = n_done;
        bus.cmd_op = 3'd2; bus.cmd_half = 1'b0; bus.cmd_dst = 2'd2;
        bus.cmd_srca = 2'd0; bus.cmd_srcb = 2'd1; bus.cmd_valid = 1'b1;
        sync();
        bus.cmd_valid = 1'b0;
        hw(2'd0, 2'd0, 8'hAA);
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", {31'b0, bus.cmd_ready}, 32'd1);
        chk("abort_no_done", n_done, nd0);
        sync();
        for (int r = 0; r < 4; r++) expect_reg("abort_reg", 2'(r), 32'h0);
        repeat (3) sync();
        chk("abort_still_no_done", n_done, nd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
